pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It replaces hard-wired stall/flush stage registers between pipeline stages: the payload is a single packed bus of arbitrary width, and backpressure is carried by `down_ready` instead of a stall input. The stage sustains one transfer per cycle under continuous flow. It registers `up_ready`, so no combinational path runs from `down_ready` to `up_ready`.

## Interface
Parameters:
- `DATA_W`, default 32: payload width in bits (≥1).
- `CLEAR_ON_FLUSH`, default 1: when 1, flush zeroes both data registers; when 0, flush clears only the valid state.

Ports:
- `clk` in, 1: clock, rising edge.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `flush` in, 1: synchronous kill of all held entries.
- `up_valid` in, 1: upstream payload valid.
- `up_ready` out, 1: stage can accept; registered and decoded from state only.
- `up_data` in, DATA_W: upstream payload.
- `down_valid` out, 1: output payload valid.
- `down_ready` in, 1: downstream accepts.
- `down_data` out, DATA_W: output payload, driven from the main register.
- `occ` out, 2: entries held (0, 1 or 2).

## Operation
- Upstream transfer (U) = `up_valid & up_ready` at a rising edge. Downstream transfer (D) = `down_valid & down_ready` at a rising edge.
- Storage: main register (`main`) and skid register (`skid`), each DATA_W bits.
- State machine, with outputs decoded from state:

  | State | Entries | down_valid | up_ready | occ |
  |---|---|---|---|---|
  | EMPTY | 0 | 0 | 1 | 0 |
  | ONE | 1 | 1 | 1 | 1 |
  | TWO | 2 | 1 | 0 | 2 |

- Transitions, evaluated when not flushing:
  - EMPTY: on U, go to ONE and load `main` <= `up_data`; otherwise hold.
  - ONE:
    - U & D: stay in ONE, `main` <= `up_data`.
    - U & !D: go to TWO, `skid` <= `up_data`, `main` held.
    - !U & D: go to EMPTY.
    - !U & !D: hold.
  - TWO: on D, go to ONE, `main` <= `skid`. No U is possible in TWO. Otherwise hold.
- Flush has highest synchronous priority:
  - Next state is EMPTY.
  - Any U in the same cycle is discarded.
  - A D in the same cycle still counts as completed downstream, because `down_valid` was 1 before the edge.
  - If CLEAR_ON_FLUSH=1, `main` and `skid` go to 0; otherwise both hold their values.
- `down_data` is held stable while `down_valid=1 & down_ready=0`. Ordering is strict FIFO: `main` is always older than `skid`.
- With `down_valid=0`, `down_data` is don't-care for protocol purposes, but it must equal the last `main` value (or 0 after reset or clearing flush). It must never show `skid` contents directly.

## Timing
- Reset (asynchronous, rst_n low): state EMPTY, `main`=`skid`=0.
  - Outputs during and after reset: `down_valid`=0, `down_data`=0, `up_ready`=1, `occ`=0.
- Reset asserted mid-operation: all held entries are lost immediately, with no completion toward downstream.
- Latency: a payload accepted at edge N appears on `down_data` with `down_valid=1` after edge N. Minimum one cycle, no combinational bypass.
- Throughput: 1 transfer/cycle while `down_ready=1`.
- Backpressure:
  - The first stalled cycle absorbs one extra beat into `skid`.
  - `up_ready` falls after that edge, so upstream may have already presented the next beat. That beat is held by upstream, not dropped.
- Recovery: the first D after a stall moves `skid` to `main`. `up_ready` returns to 1 after that edge, so a bubble-free restart takes one cycle.
- Simultaneous flush + `up_valid` + `down_ready`: the state ends in EMPTY and nothing new is held.
- All outputs change only on `clk` edges or asynchronous reset.

## Test plan
- Reset and idle:
  - During reset, and after `rst_n` rises with `up_valid`=0 for 3 cycles: `down_valid`=0, `up_ready`=1, `occ`=0, `down_data`=0.
- Streaming:
  - Stimulus: `down_ready`=1, `up_data` = 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Required: identical sequence on `down_data` one cycle later, `down_valid` high for 4 cycles, `occ` ≤1.
- Skid absorb:
  - Stimulus: send 0xA1, 0xA2 with `down_ready`=0 from cycle 1.
  - Required: `occ`=2, `up_ready`=0, `down_data`=0xA1 held.
  - Then raise `down_ready`: 0xA1, then 0xA2 delivered in order, and `up_ready`=1 one cycle after the first D.
- Flush, CLEAR_ON_FLUSH=1:
  - Stimulus: `occ`=2 holding 0xB1, 0xB2; pulse `flush` together with `up_valid` carrying 0xB3.
  - Required: next cycle `occ`=0, `down_valid`=0, `down_data`=0, and 0xB3 never appears.
- Flush, CLEAR_ON_FLUSH=0:
  - Stimulus: same sequence as the previous scenario.
  - Required: `down_valid`=0 and `down_data` remains 0xB1.
- Width and random:
  - Stimulus: DATA_W=1 and DATA_W=97 instances, 10k cycles of random `up_valid`/`down_ready`/`flush`.
  - Required (checked against a scoreboard):
    - No loss or duplication except entries killed by flush.
    - `up_ready`=0 only when `occ`=2.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// up_ready is a flop, so down_ready never reaches up_ready combinationally.
module pipe_skid_reg #(
    parameter int unsigned DATA_W         = 32,
    parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              down_valid,
    input  logic              down_ready,
    output logic [DATA_W-1:0] down_data,
    output logic [1:0]        occ
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              up_xfer;
    logic              down_xfer;

    assign up_xfer   = up_valid & up_ready;
    assign down_xfer = down_valid & down_ready;
    assign down_data = main_q;

    // State and the three handshake outputs move together so outputs stay pure flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            up_ready   <= 1'b1;
            down_valid <= 1'b0;
            occ        <= 2'd0;
        end else if (flush) begin
            state_q    <= StEmpty;
            up_ready   <= 1'b1;
            down_valid <= 1'b0;
            occ        <= 2'd0;
            if (CLEAR_ON_FLUSH) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (up_xfer) begin
                        state_q    <= StOne;
                        main_q     <= up_data;
                        down_valid <= 1'b1;
                        occ        <= 2'd1;
                    end
                end
                StOne: begin
                    if (up_xfer && down_xfer) begin
                        main_q <= up_data;
                    end else if (up_xfer) begin
                        state_q  <= StTwo;
                        skid_q   <= up_data;
                        up_ready <= 1'b0;
                        occ      <= 2'd2;
                    end else if (down_xfer) begin
                        state_q    <= StEmpty;
                        down_valid <= 1'b0;
                        occ        <= 2'd0;
                    end
                end
                StTwo: begin
                    // skid is always the younger entry; it refills main on drain
                    if (down_xfer) begin
                        state_q  <= StOne;
                        main_q   <= skid_q;
                        up_ready <= 1'b1;
                        occ      <= 2'd1;
                    end
                end
                default: begin
                    state_q    <= StEmpty;
                    up_ready   <= 1'b1;
                    down_valid <= 1'b0;
                    occ        <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random checks of pipe_skid_reg: 32-bit clearing and non-clearing
// instances for the directed scenarios, 1-bit and 97-bit instances against a queue model.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        up_valid;
    logic        down_ready;
    logic [31:0] up_data;
    logic [0:0]  up_data1;
    logic [96:0] up_data97;

    logic        a_up_ready, a_down_valid, b_up_ready, b_down_valid;
    logic [31:0] a_down_data, b_down_data;
    logic [1:0]  a_occ, b_occ, w1_occ, w97_occ;
    logic        w1_up_ready, w1_down_valid, w97_up_ready, w97_down_valid;
    logic [0:0]  w1_down_data;
    logic [96:0] w97_down_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .up_valid(up_valid), .up_ready(a_up_ready),
        .up_data(up_data), .down_valid(a_down_valid), .down_ready(down_ready),
        .down_data(a_down_data), .occ(a_occ)
    );

    pipe_skid_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .up_valid(up_valid), .up_ready(b_up_ready),
        .up_data(up_data), .down_valid(b_down_valid), .down_ready(down_ready),
        .down_data(b_down_data), .occ(b_occ)
    );

    pipe_skid_reg #(.DATA_W(1), .CLEAR_ON_FLUSH(1'b1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .up_valid(up_valid), .up_ready(w1_up_ready),
        .up_data(up_data1), .down_valid(w1_down_valid), .down_ready(down_ready),
        .down_data(w1_down_data), .occ(w1_occ)
    );

    pipe_skid_reg #(.DATA_W(97), .CLEAR_ON_FLUSH(1'b1)) dut_w97 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .up_valid(up_valid), .up_ready(w97_up_ready),
        .up_data(up_data97), .down_valid(w97_down_valid), .down_ready(down_ready),
        .down_data(w97_down_data), .occ(w97_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; down_ready = 1'b0;
        up_data = 32'h0; up_data1 = 1'b0; up_data97 = '0;
        #7;
        n_cmp++;
        if (a_down_valid !== 1'b0 || a_up_ready !== 1'b1 || a_occ !== 2'd0
            || a_down_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_during: got dv=%b ur=%b occ=%0d data=%h want 0 1 0 0",
                     a_down_valid, a_up_ready, a_occ, a_down_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (a_down_valid !== 1'b0 || a_up_ready !== 1'b1 || a_occ !== 2'd0
                || a_down_data !== 32'h0) begin
                n_err++;
                $display("FAIL reset_idle%0d: got dv=%b ur=%b occ=%0d data=%h want 0 1 0 0",
                         i, a_down_valid, a_up_ready, a_occ, a_down_data);
            end
        end
    endtask

    task automatic test_stream();
        logic [31:0] vals [4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        down_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_valid = 1'b1;
            up_data  = vals[i];
            tick();
            n_cmp++;
            if (a_down_valid !== 1'b1 || a_down_data !== vals[i] || a_occ !== 2'd1
                || a_up_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream%0d: got dv=%b data=%h occ=%0d ur=%b want 1 %h 1 1",
                         i, a_down_valid, a_down_data, a_occ, a_up_ready, vals[i]);
            end
        end
        up_valid = 1'b0;
        tick();
        n_cmp++;
        if (a_down_valid !== 1'b0 || a_occ !== 2'd0 || a_down_data !== 32'h44) begin
            n_err++;
            $display("FAIL stream_drain: got dv=%b occ=%0d data=%h want 0 0 44",
                     a_down_valid, a_occ, a_down_data);
        end
    endtask

    task automatic test_skid();
        down_ready = 1'b0;
        up_valid = 1'b1; up_data = 32'hA1;
        tick();
        n_cmp++;
        if (a_occ !== 2'd1 || a_up_ready !== 1'b1 || a_down_data !== 32'hA1) begin
            n_err++;
            $display("FAIL skid_first: got occ=%0d ur=%b data=%h want 1 1 a1",
                     a_occ, a_up_ready, a_down_data);
        end
        up_data = 32'hA2;
        tick();
        n_cmp++;
        if (a_occ !== 2'd2 || a_up_ready !== 1'b0 || a_down_valid !== 1'b1
            || a_down_data !== 32'hA1) begin
            n_err++;
            $display("FAIL skid_full: got occ=%0d ur=%b dv=%b data=%h want 2 0 1 a1",
                     a_occ, a_up_ready, a_down_valid, a_down_data);
        end
        // next beat presented while not ready must not be taken
        up_data = 32'hA3;
        tick();
        n_cmp++;
        if (a_occ !== 2'd2 || a_down_data !== 32'hA1) begin
            n_err++;
            $display("FAIL skid_hold: got occ=%0d data=%h want 2 a1", a_occ, a_down_data);
        end
        up_valid = 1'b0; down_ready = 1'b1;
        tick();
        n_cmp++;
        if (a_occ !== 2'd1 || a_up_ready !== 1'b1 || a_down_valid !== 1'b1
            || a_down_data !== 32'hA2) begin
            n_err++;
            $display("FAIL skid_recover: got occ=%0d ur=%b dv=%b data=%h want 1 1 1 a2",
                     a_occ, a_up_ready, a_down_valid, a_down_data);
        end
        tick();
        n_cmp++;
        if (a_occ !== 2'd0 || a_down_valid !== 1'b0) begin
            n_err++;
            $display("FAIL skid_empty: got occ=%0d dv=%b want 0 0", a_occ, a_down_valid);
        end
    endtask

    task automatic test_flush();
        down_ready = 1'b0; up_valid = 1'b1; up_data = 32'hB1;
        tick();
        up_data = 32'hB2;
        tick();
        n_cmp++;
        if (a_occ !== 2'd2 || b_occ !== 2'd2) begin
            n_err++;
            $display("FAIL flush_fill: got occ a=%0d b=%0d want 2 2", a_occ, b_occ);
        end
        flush = 1'b1; up_data = 32'hB3;
        tick();
        flush = 1'b0; up_valid = 1'b0;
        n_cmp++;
        if (a_occ !== 2'd0 || a_down_valid !== 1'b0 || a_down_data !== 32'h0
            || a_up_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_clear: got occ=%0d dv=%b data=%h ur=%b want 0 0 0 1",
                     a_occ, a_down_valid, a_down_data, a_up_ready);
        end
        n_cmp++;
        if (b_occ !== 2'd0 || b_down_valid !== 1'b0 || b_down_data !== 32'hB1) begin
            n_err++;
            $display("FAIL flush_keep: got occ=%0d dv=%b data=%h want 0 0 b1",
                     b_occ, b_down_valid, b_down_data);
        end
        down_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (a_down_valid !== 1'b0 || b_down_valid !== 1'b0 || a_down_data === 32'hB3
                || b_down_data === 32'hB3) begin
                n_err++;
                $display("FAIL flush_no_b3: got dv a=%b b=%b data a=%h b=%h want 0 0 not b3",
                         a_down_valid, b_down_valid, a_down_data, b_down_data);
            end
        end
        // flush together with up_valid and down_ready from a one-entry state
        up_valid = 1'b1; up_data = 32'hC1;
        tick();
        flush = 1'b1; up_data = 32'hC2;
        tick();
        flush = 1'b0; up_valid = 1'b0;
        n_cmp++;
        if (a_occ !== 2'd0 || a_down_valid !== 1'b0 || a_down_data !== 32'h0
            || b_occ !== 2'd0 || b_down_data !== 32'hC1) begin
            n_err++;
            $display("FAIL flush_simul: got occ a=%0d dv=%b data a=%h occ b=%0d data b=%h want 0 0 0 0 c1",
                     a_occ, a_down_valid, a_down_data, b_occ, b_down_data);
        end
    endtask

    task automatic test_reset_mid();
        down_ready = 1'b0; up_valid = 1'b1; up_data = 32'hD1;
        tick();
        up_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_occ !== 2'd0 || a_down_valid !== 1'b0 || a_down_data !== 32'h0
            || b_down_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid: got occ=%0d dv=%b data a=%h b=%h want 0 0 0 0",
                     a_occ, a_down_valid, a_down_data, b_down_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [0:0]  q1 [$];
        logic [96:0] q97 [$];
        logic [96:0] wide;
        int          sz;
        bit          u;
        bit          d;
        for (int c = 0; c < 10000; c++) begin
            up_valid   = ($urandom_range(0, 99) < 60);
            down_ready = ($urandom_range(0, 99) < 60);
            flush      = ($urandom_range(0, 99) < 3);
            wide       = {$urandom, $urandom, $urandom, $urandom};
            up_data97  = wide;
            up_data1   = wide[5];
            sz = q97.size();
            n_cmp++;
            if (w97_occ !== 2'(sz) || w97_down_valid !== (sz != 0)
                || w97_up_ready !== (sz != 2) || (sz != 0 && w97_down_data !== q97[0])) begin
                n_err++;
                $display("FAIL rand_w97 c%0d: got occ=%0d dv=%b ur=%b data=%h want occ=%0d head=%h",
                         c, w97_occ, w97_down_valid, w97_up_ready, w97_down_data, sz,
                         (sz != 0) ? q97[0] : 97'h0);
            end
            n_cmp++;
            if (w1_occ !== 2'(q1.size()) || w1_down_valid !== (q1.size() != 0)
                || w1_up_ready !== (q1.size() != 2)
                || (q1.size() != 0 && w1_down_data !== q1[0])) begin
                n_err++;
                $display("FAIL rand_w1 c%0d: got occ=%0d dv=%b ur=%b data=%b want occ=%0d",
                         c, w1_occ, w1_down_valid, w1_up_ready, w1_down_data, q1.size());
            end
            u = up_valid && (sz < 2);
            d = down_ready && (sz > 0);
            if (d) begin
                void'(q97.pop_front());
                void'(q1.pop_front());
            end
            if (flush) begin
                q97.delete();
                q1.delete();
            end else if (u) begin
                q97.push_back(wide);
                q1.push_back(wide[5]);
            end
            tick();
        end
        up_valid = 1'b0; flush = 1'b0; down_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
